mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported memory between the instruction-fetch stage and the data-memory stage of the pipeline. Each requester uses a level request / single-cycle acknowledge handshake. The memory uses a one-cycle enable pulse, and its Ack arrives one cycle later. The arbiter grants one requester at a time, with fixed priority to the data side. It issues the memory pulse, returns read data and ack to the owner, and recovers from a memory that never acks via a timeout.

## Interface
- TIMEOUT, 16, maximum WAIT cycles without m_ack before aborting; legal range 2..255
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- i_req  in  1  instruction fetch request, level
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  32  fetched word, valid when i_ack is high, held afterwards
- d_req  in  1  data request, level
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  32  read word, valid when d_ack is high, held afterwards
- err  out  1  pulses with i_ack or d_ack when the access timed out
- busy  out  1  high whenever state is not IDLE
- m_re  out  1  memory read-enable pulse
- m_we  out  1  memory write-enable pulse
- m_addr  out  32  memory byte address, passed unchanged
- m_wdata  out  32  memory write data
- m_ack  in  1  memory completion pulse
- m_rdata  in  32  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP. A registered owner bit records the granted side (I or D).
- IDLE:
  - If d_req is high, latch d_addr, d_wdata and d_we, set owner=D, and go to ISSUE.
  - Else if i_req is high, latch i_addr, set owner=I, and go to ISSUE. The memory operation is a read.
  - Else stay in IDLE. m_ack is ignored in IDLE.
- ISSUE, exactly one cycle:
  - Drive m_re=1 for a read or m_we=1 for a write. Never drive both.
  - m_ack is ignored in this state.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - m_re and m_we are 0. m_addr and m_wdata hold their latched values from ISSUE through WAIT.
  - If m_ack is sampled high: for a read, capture m_rdata into the owner's rdata register; a write leaves d_rdata unchanged. Go to RESP with err=0.
  - Else if the counter equals TIMEOUT-1: go to RESP with err=1. A read owner's rdata is set to 0.
  - Else increment the counter. The counter is 8 bits and cannot wrap within the legal range.
- RESP, one cycle:
  - The owner's ack is 1; the other side's ack stays 0.
  - err is 1 only if the access timed out.
  - Next state is always IDLE.
- Priority:
  - Fixed; data wins whenever both requests are sampled together.
  - A requester losing arbitration keeps req high and is served on the next IDLE evaluation.
- Requester rules:
  - Hold req, addr, we and wdata stable until the ack pulse.
  - In the cycle after ack, req must be low or represent a new transaction.
- Reset:
  - State returns to IDLE and the counter clears.
  - Outputs i_ack, d_ack, err, busy, m_re and m_we are 0. i_rdata, d_rdata, m_addr and m_wdata are 0.
  - A transaction in flight is aborted with no ack. A late m_ack arriving after reset is ignored, since the arbiter is in IDLE.
  - RST takes precedence over every other event in the same cycle.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Nominal access:
  - Cycle 0: req sampled in IDLE.
  - Cycle 1: ISSUE, m_re or m_we = 1.
  - Cycle 2: WAIT, m_ack seen.
  - Cycle 3: RESP, ack = 1.
  - Cycle 4: IDLE, may grant again.
- Request-to-ack latency is 3 cycles. Throughput is one access per 4 cycles.
- Timed-out access: ack arrives at cycle 1 + TIMEOUT + 1 after request sampling, i.e. cycle 18 for TIMEOUT=16.
- busy is high during cycles 1..3 of a nominal access.

## Test plan
- Fetch only: i_req=1, i_addr=0x8, memory word 2 = 0x2002000A.
  - Required: m_re=1 in cycle 1 only, m_addr=0x8, i_ack=1 in cycle 3, i_rdata=0x2002000A, err=0, d_ack never high.
- Data read: d_req=1, d_we=0, d_addr=0x10.
  - Required: m_re pulse in cycle 1, d_ack in cycle 3, d_rdata equals memory word 4, i_rdata unchanged.
- Contention: i_req and d_req both raised in cycle 0 and held until their acks.
  - Required: d_ack in cycle 3, then m_re for the fetch in cycle 5, i_ack in cycle 7.
- Data write: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF.
  - Required: m_we=1 and m_re=0 in cycle 1, m_wdata=0xDEADBEEF, d_ack in cycle 3, d_rdata unchanged.
  - A subsequent read of 0x20 returns 0xDEADBEEF.
- Timeout: memory model never acks, TIMEOUT=16, i_req=1.
  - Required: i_ack=1 and err=1 in cycle 18, i_rdata=0, state returns to IDLE.
  - A following access with a responsive memory completes with err=0.
- Reset mid-WAIT: RST=1 in cycle 2 while m_ack=1.
  - Required: no ack is issued, all outputs are 0 in the cycle after reset, and busy=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported memory between instruction fetch and data access.
// Data has fixed priority; a memory that never acks is recovered by a WAIT-state timeout.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        busy,
  output logic        m_re,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        owner_d, owner_d_nxt;
  logic        we_q, we_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] addr_nxt, wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic        i_ack_nxt, d_ack_nxt, err_nxt, busy_nxt, m_re_nxt, m_we_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      we_q    <= 1'b0;
      cnt     <= 8'd0;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
      i_rdata <= 32'd0;
      d_rdata <= 32'd0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      m_re    <= 1'b0;
      m_we    <= 1'b0;
    end else begin
      state   <= state_nxt;
      owner_d <= owner_d_nxt;
      we_q    <= we_nxt;
      cnt     <= cnt_nxt;
      m_addr  <= addr_nxt;
      m_wdata <= wdata_nxt;
      i_rdata <= i_rdata_nxt;
      d_rdata <= d_rdata_nxt;
      i_ack   <= i_ack_nxt;
      d_ack   <= d_ack_nxt;
      err     <= err_nxt;
      busy    <= busy_nxt;
      m_re    <= m_re_nxt;
      m_we    <= m_we_nxt;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_nxt   = state;
    owner_d_nxt = owner_d;
    we_nxt      = we_q;
    cnt_nxt     = cnt;
    addr_nxt    = m_addr;
    wdata_nxt   = m_wdata;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
    i_ack_nxt   = 1'b0;
    d_ack_nxt   = 1'b0;
    err_nxt     = 1'b0;
    m_re_nxt    = 1'b0;
    m_we_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req) begin
          owner_d_nxt = 1'b1;
          we_nxt      = d_we;
          addr_nxt    = d_addr;
          wdata_nxt   = d_wdata;
          m_re_nxt    = ~d_we;
          m_we_nxt    = d_we;
          state_nxt   = ISSUE;
        end else if (i_req) begin
          owner_d_nxt = 1'b0;
          we_nxt      = 1'b0;
          addr_nxt    = i_addr;
          m_re_nxt    = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = 8'd0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (m_ack || cnt == CNT_LAST) begin
          state_nxt = RESP;
          d_ack_nxt = owner_d;
          i_ack_nxt = ~owner_d;
          err_nxt   = ~m_ack;
          // A timed-out read returns zero rather than stale data.
          if (!we_q) begin
            if (owner_d) d_rdata_nxt = m_ack ? m_rdata : 32'd0;
            else         i_rdata_nxt = m_ack ? m_rdata : 32'd0;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions against a small memory
// model, plus contention and reset-during-WAIT sequences.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err, busy, m_re, m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'd0;

  logic        ack_en = 1'b1;
  logic [31:0] mem [16];

  int total = 0;
  int bad = 0;
  logic [31:0] exp_i = 32'd0;
  logic [31:0] exp_d = 32'd0;

  mem_port_arbiter #(.TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .err(err), .busy(busy),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 CLK = ~CLK;

  // Memory acks one cycle after an enable pulse unless ack_en is low.
  always @(posedge CLK) begin
    m_ack <= 1'b0;
    if (ack_en && (m_re || m_we)) begin
      m_ack <= 1'b1;
      if (m_we) mem[m_addr[5:2]] <= m_wdata;
      else      m_rdata <= mem[m_addr[5:2]];
    end
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack_en;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int ack_cyc;
    logic own_ack, other_ack;
    ack_cyc = -1;
    ack_en  = v.ack_en;
    d_we    = v.we;
    d_addr  = v.addr;
    d_wdata = v.wdata;
    i_addr  = v.addr;
    d_req   = v.is_d;
    i_req   = ~v.is_d;
    for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
      step();
      own_ack   = v.is_d ? d_ack : i_ack;
      other_ack = v.is_d ? i_ack : d_ack;
      check("m_re", {31'd0, m_re}, {31'd0, c == 1 && !(v.is_d && v.we)});
      check("m_we", {31'd0, m_we}, {31'd0, c == 1 && v.is_d && v.we});
      check("busy", {31'd0, busy}, 32'd1);
      check("other_ack", {31'd0, other_ack}, 32'd0);
      if (c == 1) check("m_addr", m_addr, v.addr);
      if (c == 1 && v.is_d && v.we) check("m_wdata", m_wdata, v.wdata);
      if (own_ack) begin
        ack_cyc = c;
        check("err", {31'd0, err}, {31'd0, v.exp_err});
        check("own_rdata", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        check("other_rdata", v.is_d ? i_rdata : d_rdata, v.is_d ? exp_i : exp_d);
        d_req = 1'b0;
        i_req = 1'b0;
      end else begin
        check("err_idle", {31'd0, err}, 32'd0);
      end
    end
    check("ack_cycle", ack_cyc, v.exp_lat);
    d_req = 1'b0;
    i_req = 1'b0;
    if (v.is_d) exp_d = v.exp_rdata;
    else        exp_i = v.exp_rdata;
    step();
    check("busy_after", {31'd0, busy}, 32'd0);
    check("acks_after", {30'd0, i_ack, d_ack}, 32'd0);
    ack_en = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {26'd0, i_ack, d_ack, err, busy, m_re, m_we}, 32'd0);
    check({tag, "_i_rdata"}, i_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
    check({tag, "_m_addr"}, m_addr, 32'd0);
    check({tag, "_m_wdata"}, m_wdata, 32'd0);
  endtask

  initial begin
    int d_ack_cyc, i_ack_cyc, re2_cyc, re_cnt;
    logic [31:0] re2_addr;

    for (int k = 0; k < 16; k++) mem[k] = {16'(k * 4097), 16'(k * 5)};

    //        is_d  we    addr          wdata          ack   exp_rdata      err   lat
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h2002_000A, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h4004_0014, 1'b0, 3};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b1, 32'h4004_0014, 1'b0, 3};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0,         1'b1, 18};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h1001_0005, 1'b0, 3};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_1234, 1'b0, 32'hDEAD_BEEF, 1'b1, 18};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0,         1'b0, 3};

    RST = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    RST = 1'b0;
    step();
    check_all_zero("post_reset");

    foreach (vecs[n]) run_vec(vecs[n]);

    // Contention: both requests raised together, data must win.
    d_ack_cyc = -1; i_ack_cyc = -1; re2_cyc = -1; re_cnt = 0; re2_addr = 32'd0;
    d_we = 1'b0; d_addr = 32'h14; i_addr = 32'hC;
    d_req = 1'b1; i_req = 1'b1;
    for (int c = 1; c <= 20 && i_ack_cyc < 0; c++) begin
      step();
      if (m_re) begin
        re_cnt++;
        if (re_cnt == 2) begin re2_cyc = c; re2_addr = m_addr; end
      end
      if (d_ack) begin
        d_ack_cyc = c;
        check("cont_d_rdata", d_rdata, 32'h5005_0019);
        d_req = 1'b0;
      end
      if (i_ack) begin
        i_ack_cyc = c;
        check("cont_i_rdata", i_rdata, 32'h3003_000F);
        i_req = 1'b0;
      end
    end
    d_req = 1'b0; i_req = 1'b0;
    check("cont_d_ack_cycle", d_ack_cyc, 3);
    check("cont_fetch_re_cycle", re2_cyc, 5);
    check("cont_fetch_addr", re2_addr, 32'hC);
    check("cont_i_ack_cycle", i_ack_cyc, 7);
    step();
    exp_d = 32'h5005_0019;
    exp_i = 32'h3003_000F;

    // Reset asserted in WAIT while the memory ack is present.
    d_we = 1'b0; d_addr = 32'h10; d_req = 1'b1;
    step();
    step();
    check("rst_wait_m_ack", {31'd0, m_ack}, 32'd1);
    RST = 1'b1;
    step();
    check_all_zero("rst_wait");
    RST = 1'b0;
    d_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("rst_wait_quiet", {28'd0, i_ack, d_ack, busy, err}, 32'd0);
    end
    exp_i = 32'd0;
    exp_d = 32'd0;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule
